data_mem_responder: RTL and testbench

- Responder end of the pipeline's data-memory port.
- Accepts load/store requests from the memory stage: address, write data, byte enables and write strobe.
- Inserts a configurable number of wait states, driving `stall` to freeze the pipeline until the access completes.
- Returns registered read data that the write-back pipeline register captures.

---
 rtl/data_mem_responder_pkg.sv | 36 +++
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/data_mem_responder_ram.sv | 46 ++++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types, widths and the lane-merge helper for the
//               data-memory responder.
// Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [LANES-1:0]  lane_en
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Memory-stage <-> data-memory request/response bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface data_mem_responder_if;
    import mem_pkg::*;

    logic                mem_req;
    logic                mem_we;
    logic [31:0]         addr;
    logic [WORD_W-1:0]   wdata;
    logic [LANES-1:0]    byte_en;
    logic [WORD_W-1:0]   rdata;
    logic                ack;
    logic                stall;
    logic                err;

    // Pipeline memory stage side
    modport master (
        output mem_req, mem_we, addr, wdata, byte_en,
        input  rdata, ack, stall, err
    );

    // Data-memory responder side
    modport slave (
        input  mem_req, mem_we, addr, wdata, byte_en,
        output rdata, ack, stall, err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_ram
// Description : 2^DEPTH_LOG2 x 32 word array with per-lane writes and a
//               registered, resettable read port.
// Revision    : 1.0  initial release
// ============================================================================
module byte_lane_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_we,
    input  wire logic                  i_re,
    input  wire logic                  i_rd_zero,
    input  wire logic [DEPTH_LOG2-1:0] i_idx,
    input  wire logic [WORD_W-1:0]     i_wdata,
    input  wire logic [LANES-1:0]      i_be,
    output logic      [WORD_W-1:0]     o_rdata
);

    logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [WORD_W-1:0] r_rdata;

    // Array write: only enabled lanes change; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we && (|i_be)) begin
            r_mem[i_idx] <= lane_merge(r_mem[i_idx], i_wdata, i_be);
        end
    end

    // Read register: loads on a read access, forced to zero for rejected addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Wait-state inserting responder for the pipeline data-memory
//               port. Freezes the pipeline with stall, pulses ack on completion.
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    data_mem_responder_if.slave  bus
);

    localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;
    logic               w_capture;

    logic [31:0]        r_addr;
    logic               r_we;
    logic [WORD_W-1:0]  r_wdata;
    logic [LANES-1:0]   r_be;
    logic               r_err;

    logic               w_access;
    logic [31:0]        w_acc_addr;
    logic               w_acc_we;
    logic [WORD_W-1:0]  w_acc_wdata;
    logic [LANES-1:0]   w_acc_be;
    logic               w_oor;
    logic               w_unused_addr_lsb;

    // With zero wait states the access happens on the accepting edge, before
    // the request registers have loaded, so take the live bus values there.
    assign w_acc_addr  = (r_state == IDLE) ? bus.addr    : r_addr;
    assign w_acc_we    = (r_state == IDLE) ? bus.mem_we  : r_we;
    assign w_acc_wdata = (r_state == IDLE) ? bus.wdata   : r_wdata;
    assign w_acc_be    = (r_state == IDLE) ? bus.byte_en : r_be;

    assign w_access = ((r_state == IDLE) && bus.mem_req && (c_WAIT == 4'd0)) ||
                      ((r_state == WAIT) && (r_cnt == 4'd1));

    assign w_oor             = (w_acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign w_unused_addr_lsb = ^w_acc_addr[1:0];

    // State, counter and request capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_addr  <= bus.addr;
                r_we    <= bus.mem_we;
                r_wdata <= bus.wdata;
                r_be    <= bus.byte_en;
            end
        end
    end

    // Next-state and counter decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_req) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = c_WAIT;
                    w_state_next = (c_WAIT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Error flag registered alongside the access it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_access) begin
            r_err <= w_oor;
        end
    end

    byte_lane_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .rst       (reset),
        .i_we      (w_access & w_acc_we & ~w_oor),
        .i_re      (w_access & ~w_acc_we),
        .i_rd_zero (w_oor),
        .i_idx     (w_acc_addr[DEPTH_LOG2+1:2]),
        .i_wdata   (w_acc_wdata),
        .i_be      (w_acc_be),
        .o_rdata   (bus.rdata)
    );

    assign bus.ack   = (r_state == RESP);
    assign bus.err   = (r_state == RESP) & r_err;
    assign bus.stall = ((r_state == IDLE) && bus.mem_req) || (r_state == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench; instance A uses two wait
//               states, instance B uses zero wait states.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic drive(input int sel, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (sel == 0) begin
            bus_a.mem_req = req; bus_a.mem_we = we; bus_a.addr = a;
            bus_a.wdata = wd; bus_a.byte_en = be;
        end else begin
            bus_b.mem_req = req; bus_b.mem_we = we; bus_b.addr = a;
            bus_b.wdata = wd; bus_b.byte_en = be;
        end
    endtask

    task automatic sample(input int sel, output logic st, output logic ak,
                          output logic [31:0] rd, output logic er);
        if (sel == 0) begin
            st = bus_a.stall; ak = bus_a.ack; rd = bus_a.rdata; er = bus_a.err;
        end else begin
            st = bus_b.stall; ak = bus_b.ack; rd = bus_b.rdata; er = bus_b.err;
        end
    endtask

    // One complete access; optionally switches addr to alt_a at cycle chg_cyc.
    task automatic acc(input int sel, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int chg_cyc, input logic [31:0] alt_a,
                       output logic [31:0] rd, output logic e,
                       output int stall_n, output int ack_c);
        logic st, ak, er;
        logic [31:0] r;
        @(posedge clk); #1;
        drive(sel, 1'b1, we, a, wd, be);
        stall_n = 0; ack_c = -1; rd = '0; e = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == chg_cyc) drive(sel, 1'b1, we, alt_a, wd, be);
            @(negedge clk);
            sample(sel, st, ak, r, er);
            if (st) stall_n++;
            if (ak) begin
                ack_c = c; rd = r; e = er;
                break;
            end
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (ack_c < 0) begin
            failures++;
            $display("FAIL ack_timeout addr=%h got no ack required ack within 20 cycles", a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_a.ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b required=0", bus_a.ack); end
        checks++; if (bus_a.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", bus_a.err); end
        checks++; if (bus_a.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h required=00000000", bus_a.rdata); end
        checks++; if (bus_a.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b required=0", bus_a.stall); end
        bus_a.mem_req = 1'b1; #1;
        checks++; if (bus_a.stall !== 1'b1) begin failures++; $display("FAIL reset_stall_req got=%b required=1", bus_a.stall); end
        bus_a.mem_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int sn, ac;
        acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (sn !== 3) begin failures++; $display("FAIL store_stall_cycles got=%0d required=3", sn); end
        checks++; if (ac !== 3) begin failures++; $display("FAIL store_ack_cycle got=%0d required=3", ac); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL store_err got=%b required=0", e); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata_unchanged got=%h required=00000000", rd); end
        acc(0, 1'b0, 32'h10, 32'h0, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (sn !== 3) begin failures++; $display("FAIL load_stall_cycles got=%0d required=3", sn); end
        checks++; if (ac !== 3) begin failures++; $display("FAIL load_ack_cycle got=%0d required=3", ac); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h required=deadbeef", rd); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL load_err got=%b required=0", e); end
        repeat (2) @(negedge clk);
        checks++; if (bus_a.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rdata_hold got=%h required=deadbeef", bus_a.rdata); end
        checks++; if (bus_a.ack !== 1'b0) begin failures++; $display("FAIL ack_single_pulse got=%b required=0", bus_a.ack); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; logic e; int sn, ac;
        acc(0, 1'b1, 32'h20, 32'h11223344, 4'hF, -1, 32'h0, rd, e, sn, ac);
        acc(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, -1, 32'h0, rd, e, sn, ac);
        acc(0, 1'b0, 32'h20, 32'h0, 4'h0, -1, 32'h0, rd, e, sn, ac);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL lane_merge got=%h required=11bb33dd", rd); end
        acc(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, -1, 32'h0, rd, e, sn, ac);
        checks++; if (ac !== 3) begin failures++; $display("FAIL be0_ack_cycle got=%0d required=3", ac); end
        acc(0, 1'b0, 32'h23, 32'h0, 4'h1, -1, 32'h0, rd, e, sn, ac);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be0_unaligned_load got=%h required=11bb33dd", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e; int sn, ac;
        acc(0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, -1, 32'h0, rd, e, sn, ac);
        acc(0, 1'b1, 32'h1000, 32'h5, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_store_err got=%b required=1", e); end
        checks++; if (ac !== 3) begin failures++; $display("FAIL oor_store_ack_cycle got=%0d required=3", ac); end
        acc(0, 1'b0, 32'h1000, 32'h0, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_load_err got=%b required=1", e); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_load_rdata got=%h required=00000000", rd); end
        acc(0, 1'b0, 32'h0, 32'h0, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (rd !== 32'h0BADC0DE) begin failures++; $display("FAIL oor_word0_kept got=%h required=0badc0de", rd); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL inrange_err got=%b required=0", e); end
    endtask

    task automatic test_req_change();
        logic [31:0] rd; logic e; int sn, ac;
        acc(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, 32'h20, rd, e, sn, ac);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL req_change_rdata got=%h required=deadbeef", rd); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic e; int sn, ac;
        acc(1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (sn !== 1) begin failures++; $display("FAIL zw_stall_cycles got=%0d required=1", sn); end
        checks++; if (ac !== 1) begin failures++; $display("FAIL zw_ack_cycle got=%0d required=1", ac); end
        acc(1, 1'b1, 32'hC, 32'h5A5A5A5A, 4'hF, -1, 32'h0, rd, e, sn, ac);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if (bus_b.stall !== 1'b1 || bus_b.ack !== 1'b0) begin failures++; $display("FAIL b2b_c0 got stall=%b ack=%b required stall=1 ack=0", bus_b.stall, bus_b.ack); end
        @(negedge clk);
        checks++; if (bus_b.ack !== 1'b1 || bus_b.stall !== 1'b0 || bus_b.rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL b2b_c1 got ack=%b stall=%b rdata=%h required ack=1 stall=0 rdata=a5a5a5a5", bus_b.ack, bus_b.stall, bus_b.rdata); end
        drive(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if (bus_b.stall !== 1'b1 || bus_b.ack !== 1'b0) begin failures++; $display("FAIL b2b_c2 got stall=%b ack=%b required stall=1 ack=0", bus_b.stall, bus_b.ack); end
        @(negedge clk);
        checks++; if (bus_b.ack !== 1'b1 || bus_b.rdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_c3 got ack=%b rdata=%h required ack=1 rdata=5a5a5a5a", bus_b.ack, bus_b.rdata); end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic e; int sn, ac;
        acc(0, 1'b1, 32'h40, 32'h12345678, 4'hF, -1, 32'h0, rd, e, sn, ac);
        acc(0, 1'b0, 32'h40, 32'h0, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL rw_preload got=%h required=12345678", rd); end
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checks++; if (bus_a.ack !== 1'b0 || bus_a.err !== 1'b0 || bus_a.stall !== 1'b0 || bus_a.rdata !== 32'h0) begin failures++; $display("FAIL rw_outputs got ack=%b err=%b stall=%b rdata=%h required all 0", bus_a.ack, bus_a.err, bus_a.stall, bus_a.rdata); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        acc(0, 1'b0, 32'h40, 32'h0, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL rw_store_aborted got=%h required=12345678", rd); end
    endtask

    task automatic test_reset_resp();
        logic [31:0] rd; logic e; int sn, ac;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h44, 32'h00000077, 4'hF);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_a.ack) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL rr_ack_timeout got no ack required ack"); end
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checks++; if (bus_a.ack !== 1'b0 || bus_a.rdata !== 32'h0) begin failures++; $display("FAIL rr_outputs got ack=%b rdata=%h required ack=0 rdata=00000000", bus_a.ack, bus_a.rdata); end
        @(posedge clk);
        #1 reset = 1'b0;
        acc(0, 1'b0, 32'h44, 32'h0, 4'hF, -1, 32'h0, rd, e, sn, ac);
        checks++; if (rd !== 32'h00000077) begin failures++; $display("FAIL rr_store_kept got=%h required=00000077", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_merge();
        test_out_of_range();
        test_req_change();
        test_zero_wait();
        test_reset_wait();
        test_reset_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
